seq_multiplier: RTL

Iterative shift-add multiplier with valid/ready handshakes and per-transaction signed/unsigned mode, parametrised in operand width. It is the area-lean successor to the combinational 8×8 multipliers in the convolution datapath. Convolution kernels feed it one operand pair at a time and collect the full-width product downstream. One multiplication is in flight at a time; throughput is one product per WIDTH+2 cycles with no backpressure.

---
 rtl/seq_multiplier_pkg.sv | 12 +
 rtl/seq_multiplier_if.sv | 26 ++
 rtl/seq_mult_core.sv | 43 ++++
 rtl/seq_multiplier.sv | 89 ++++++++
 4 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the iterative shift-add multiplier: state encoding and default width.
package seq_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/product handshake bundle between a convolution kernel and seq_multiplier.
interface seq_multiplier_if
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_mult_core.sv
// Shift-add datapath: multiplicand/multiplier shift registers, 2*WIDTH accumulator and iteration counter.
module seq_mult_core #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a_mag,
  input  logic [WIDTH-1:0]   i_b_mag,
  output logic [2*WIDTH-1:0] o_acc_next,
  output logic               o_last
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;

  // Exposed so the top can capture the final sum on the WIDTH-th iteration edge.
  assign o_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_last     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a_mag};
      r_mplier <= i_b_mag;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_acc    <= o_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned multiplier: FSM and handshakes; arithmetic lives in seq_mult_core.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic             clk,
  input logic             rst_n,
  seq_multiplier_if.slave bus
);
  state_e             r_state;
  logic               r_neg;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_load;
  logic               w_step;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_last;

  // Negating the most negative value wraps to 2^(WIDTH-1), which is the right unsigned magnitude.
  assign w_a_mag = (bus.signed_mode & bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_b_mag = (bus.signed_mode & bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign w_load  = (r_state == ST_IDLE) & bus.in_valid;
  assign w_step  = (r_state == ST_BUSY);

  seq_mult_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_a_mag   (w_a_mag),
    .i_b_mag   (w_b_mag),
    .o_acc_next(w_acc_next),
    .o_last    (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_neg       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_product   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_neg      <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_last) begin
            r_product   <= r_neg ? -w_acc_next : w_acc_next;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.product   = r_product;
endmodule
